// File: rtl/regfile_write_queue.sv
// regfile_write_queue: buffers writeback results and drains them in order into the register file write port
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  input  logic                       drain_en,
  output logic [AW-1:0]              a3,
  output logic                       we3,
  output logic [DW-1:0]              wd3,
  input  logic [AW-1:0]              ra1,
  input  logic [AW-1:0]              ra2,
  output logic                       hit1,
  output logic                       hit2,
  output logic [DW-1:0]              fwd1,
  output logic [DW-1:0]              fwd2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic push, pop;
  assign empty = count == '0;
  assign full = count == (PW+1)'(DEPTH);
  assign in_ready = !full && !reset;
  assign we3 = !empty && drain_en && !reset;
  assign push = in_valid && in_ready;
  assign pop = we3;
  assign a3 = empty ? '0 : addr_q[head];
  assign wd3 = empty ? '0 : data_q[head];
  function automatic logic [DW:0] lookup(input logic [AW-1:0] ra);
    logic [DW:0] r;
    logic [PW-1:0] idx;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (i < int'(count) && addr_q[idx] == ra) r = {1'b1, data_q[idx]};
    end
    return r;
  endfunction
  // scan from oldest to youngest so the youngest match wins
  always_comb begin
    {hit1, fwd1} = lookup(ra1);
    {hit2, fwd2} = lookup(ra2);
  end
  // entry storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= in_addr;
      data_q[tail] <= in_data;
    end
  end
  // pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end
endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Write-side initiator for the 3-port register file. It owns the single write port (A3/WE3/WD3) and issues writes to the register file.
- Accepts writeback results from execute/memory stages over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It drains one entry per cycle into the register file whenever DRAIN_EN permits.
- Provides forwarding lookups for both read addresses, so readers see pending (not yet written) values.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, >= 2
AW, 5, register address width; matches A1/A2/A3
DW, 32, data width; matches WD3/RD1/RD2

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
IN_VALID  input  1  writeback request valid
IN_READY  output  1  queue can accept a request this cycle
IN_ADDR  input  AW  destination register of request
IN_DATA  input  DW  data of request
DRAIN_EN  input  1  register file write port may be used this cycle
A3  output  AW  register file write address (head entry)
WE3  output  1  register file write enable
WD3  output  DW  register file write data (head entry)
RA1  input  AW  read address 1 (same value driven to register file A1)
RA2  input  AW  read address 2 (same value driven to register file A2)
HIT1  output  1  a pending entry matches RA1
HIT2  output  1  a pending entry matches RA2
FWD1  output  DW  forwarded data for RA1
FWD2  output  DW  forwarded data for RA2
COUNT  output  log2(DEPTH)+1  occupied entries
EMPTY  output  1  COUNT == 0
FULL  output  1  COUNT == DEPTH

Behaviour:
- State: DEPTH x {addr, data} storage, head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, and the COUNT register.
- Reset (RESET high at rising edge): head = tail = 0, COUNT = 0. Storage contents are don't-care.
- Reset outputs: EMPTY = 1, FULL = 0, IN_READY = 1, WE3 = 0, HIT1 = HIT2 = 0, FWD1 = FWD2 = 0, A3 = 0, WD3 = 0.
- Reset mid-operation discards all pending entries. While RESET is high, WE3 is forced to 0 and IN_READY is forced to 0; no write reaches the register file in the reset cycle.
- IN_READY = !FULL && !RESET. It depends only on registered state, not on IN_VALID.
- A push occurs when IN_VALID && IN_READY: the entry is written at tail, and tail advances by 1.
- A push with FULL asserted is refused, even if a pop occurs in the same cycle. The requester must hold IN_ADDR/IN_DATA stable until accepted.
- WE3 = !EMPTY && DRAIN_EN && !RESET.
- A3 and WD3 carry the head entry whenever !EMPTY, and are 0 when EMPTY.
- A pop occurs when WE3 is high: head advances by 1. The register file captures WD3 on the same edge.
- Latency: an accepted request can appear on WE3 at the earliest in the cycle after acceptance. There is no same-cycle fall-through.
- COUNT update: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop (possible only when not FULL and not EMPTY).
- Wrap-around: pointers roll from DEPTH-1 to 0. FIFO order is strictly preserved across the wrap.
- Forwarding for each read port n:
  - HITn = 1 if any occupied entry has addr == RAn. The comparison uses the full AW bits; there is no special treatment of register 0.
  - FWDn = data of the youngest matching entry (closest to tail). FWDn = 0 when there is no hit.
- The head entry being written this cycle still counts as a hit, because the register file only updates at the edge.
- A request being pushed this cycle is not visible to forwarding until the next cycle.
- Duplicate addresses in the queue are allowed and are not coalesced. Each entry is written in order, so the final register value equals the youngest data.
- FWD/HIT are combinational from storage and RA inputs. All other outputs are combinational from registered state plus DRAIN_EN/RESET only.

Test Plan:
- Reset, then IN_VALID=1 with IN_ADDR=3, IN_DATA=0xDEADBEEF, DRAIN_EN=1 -> IN_READY=1. Next cycle: WE3=1, A3=3, WD3=0xDEADBEEF. Following cycle: EMPTY=1, WE3=0.
- DRAIN_EN=0, push addrs 1,2,3,4 with data 0x11..0x44 -> COUNT=4, FULL=1, IN_READY=0, WE3=0. A 5th request is held, not accepted, and COUNT stays 4.
- From full, raise DRAIN_EN=1 with IN_VALID held -> pop 0x11 to A3=1. In that cycle the held request is not accepted. In the next cycle the request is pushed and a pop occurs simultaneously, so COUNT stays 3. Drain order is 1,2,3,4, then the held request, wrapping tail past index 3.
- DRAIN_EN=0, push (5,0xA), (5,0xB), (6,0xC); RA1=5, RA2=7 -> HIT1=1, FWD1=0xB, HIT2=0, FWD2=0. Then drain fully -> writes 5:0xA, 5:0xB, 6:0xC in order, and HIT1 stays 1 through the cycle in which 5:0xB is on WD3.
- With COUNT=3 and DRAIN_EN=1, assert RESET for one cycle -> WE3=0 and IN_READY=0 during reset. Afterwards COUNT=0, EMPTY=1, HIT1=HIT2=0, and no further writes occur.
- Push (2,0x55) with RA1=2 in the same cycle -> HIT1=0 that cycle, HIT1=1 with FWD1=0x55 the next cycle (DRAIN_EN=0).
